clock_set_ctrl: RTL
===================

# clock_set_ctrl

Button-driven set-mode controller for the 12-hour BCD clock. It freezes the running clock, lets the user edit hours, minutes and seconds with increment and decrement buttons, and drives field blinking on the 8-digit multiplexed display. It then commits the edited time back to the clock with a one-cycle load pulse. It sits between the debounced board buttons, the seconds-enable divider, the time counters and the seven-segment scanner.

## Interface
- BLINK_TICKS, 5: `tick` pulses per half blink period.
- TIMEOUT_TICKS, 100: `tick` pulses of button inactivity before auto-exit. Used only when the macro is defined.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- tick  in  1  one-cycle pulse at 10 Hz from the divider
- btn_mode  in  1  debounced, synchronized level
- btn_inc  in  1  debounced, synchronized level
- btn_dec  in  1  debounced, synchronized level
- cur_time  in  24  live BCD {hh,mm,ss} from the clock
- cur_pm  in  1  live PM flag from the clock
- run_en  out  1  gates the clock's seconds enable; 1 only in RUN
- load  out  1  one-cycle commit strobe
- load_time  out  24  BCD {hh,mm,ss} to load; valid while `load`=1
- load_pm  out  1  PM flag to load
- mode  out  2  0=RUN, 1=SET_HH, 2=SET_MM, 3=SET_SS
- blank_mask  out  8  1 = blank that display digit; bit0 = ss units … bit5 = hh tens; bits 7:6 always 0

## Operation
- Button handling: each button is registered, and an action fires only on its rising edge. One press produces one action, regardless of hold time.
- Priority in the same cycle: a mode edge beats inc/dec. If inc and dec edges coincide, both are ignored.
- FSM:
  - RUN + mode edge: capture `cur_time`/`cur_pm` into the edit registers, then go to SET_HH.
  - SET_HH → SET_MM → SET_SS on each mode edge.
  - SET_SS + mode edge: go to RUN and issue `load`.
- Hour edit (BCD, range 01..12):
  - inc: 12→01. 11→12 toggles pm.
  - dec: 01→12. 12→11 toggles pm.
  - A value outside 01..12 becomes 01 on inc or 12 on dec, with no pm change.
- Minute and second edit (BCD, range 00..59):
  - Wrap 59↔00, with no carry into other fields.
  - An invalid value becomes 00 on inc or 59 on dec.
- Blink:
  - The phase flips every BLINK_TICKS ticks while in a SET state.
  - In the blank phase, the two digits of the field being edited are masked.
  - The phase resets to visible on field entry and on every inc/dec action.
  - In RUN, `blank_mask` = 0.
- `load_time`/`load_pm` hold the last committed values between loads.

## Timing
- Reset values: `mode`=RUN, `run_en`=1, `load`=0, `load_time`=24'h120000, `load_pm`=0, `blank_mask`=0, edit registers = 12:00:00 AM, blink and timeout counters = 0.
- A button rising in cycle N is detected at the clk edge ending cycle N. The new `mode` and edit value are visible in cycle N+1.
- `run_en` is decoded from the `mode` register, so it is 0 from the first SET cycle onward.
- `load` is registered and is high for exactly the first RUN cycle after SET_SS. `run_en` is 1 in that same cycle.
- The clock gives `load` priority over any enable in that same cycle.
- Reset asserted mid-edit: edits are discarded immediately and asynchronously, no `load` is issued, and the block returns to RUN.
- The input `tick` is ignored in RUN, apart from having no effect.

## Configuration
- Macro: `CLOCK_SET_TIMEOUT_EN`.
- Defined: in any SET state, a counter increments on each `tick` and clears on any button edge. When it reaches TIMEOUT_TICKS, the block returns to RUN without `load`, so edits are discarded and the clock resumes from its frozen value.
- Undefined: the counter is not built, and a SET state persists until a mode press.

## Test plan
- Reset, then idle 50 ticks → `mode`=0, `run_en`=1, `load` never asserted, `blank_mask`=0.
- `cur_time`=11:59:30 AM; press mode, inc (hour), mode, mode, mode → exactly one `load` pulse with `load_time`=24'h125930, `load_pm`=1, and `run_en`=1 in the same cycle.
- In SET_HH at 01: press dec → 12 with pm unchanged. In SET_MM at 00: press dec → 59. Press inc and dec in the same cycle → no change.
- In SET_MM with no presses for 20 ticks, BLINK_TICKS=5 → `blank_mask` toggles 8'h00/8'h0C every 5 ticks. An inc press forces 8'h00 on the next cycle.
- Hold btn_inc high for 1000 cycles in SET_SS → the seconds value advances by exactly 1.
- With `CLOCK_SET_TIMEOUT_EN` and TIMEOUT_TICKS=100, enter SET_HH and idle 100 ticks → `mode`=0 with no `load`. Repeat without the macro → still SET_HH after 200 ticks. Assert reset mid-SET_MM → `mode`=0 and no `load`.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven set mode for the 12-hour BCD clock (freeze, edit, blink, commit).
// Optional inactivity auto-exit is built only when CLOCK_SET_TIMEOUT_EN is defined.
module clock_set_ctrl #(
  parameter int unsigned BLINK_TICKS   = 5,
  parameter int unsigned TIMEOUT_TICKS = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] cur_time,
  input  logic        cur_pm,
  output logic        run_en,
  output logic        load,
  output logic [23:0] load_time,
  output logic        load_pm,
  output logic [1:0]  mode,
  output logic [7:0]  blank_mask
);

  localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               btn_mode_q, btn_inc_q, btn_dec_q;
  logic               mode_edge, inc_edge, dec_edge, any_edge;
  logic [7:0]         hh_q, mm_q, ss_q;
  logic [7:0]         hh_d, mm_d, ss_d;
  logic               pm_q, pm_d;
  logic [8:0]         hh_step;
  logic               load_d, load_pm_d, run_en_d;
  logic [23:0]        load_time_d;
  logic [7:0]         blank_mask_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d, blink_rst;
  logic               tmo_hit;

  function automatic logic hour_ok(input logic [7:0] v);
    return ((v[7:4] == 4'd0) && (v[3:0] != 4'd0) && (v[3:0] <= 4'd9)) ||
           ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
  endfunction

  function automatic logic ms_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  // Returns {pm_toggle, new_hour}.
  function automatic logic [8:0] hour_inc(input logic [7:0] v);
    if (!hour_ok(v))  return {1'b0, 8'h01};
    if (v == 8'h12)   return {1'b0, 8'h01};
    if (v == 8'h11)   return {1'b1, 8'h12};
    if (v == 8'h09)   return {1'b0, 8'h10};
    return {1'b0, v + 8'h01};
  endfunction

  function automatic logic [8:0] hour_dec(input logic [7:0] v);
    if (!hour_ok(v))  return {1'b0, 8'h12};
    if (v == 8'h01)   return {1'b0, 8'h12};
    if (v == 8'h12)   return {1'b1, 8'h11};
    if (v == 8'h10)   return {1'b0, 8'h09};
    return {1'b0, v - 8'h01};
  endfunction

  function automatic logic [7:0] ms_inc(input logic [7:0] v);
    if (!ms_ok(v) || (v == 8'h59)) return 8'h00;
    if (v[3:0] == 4'd9)            return {v[7:4] + 4'd1, 4'd0};
    return v + 8'h01;
  endfunction

  function automatic logic [7:0] ms_dec(input logic [7:0] v);
    if (!ms_ok(v) || (v == 8'h00)) return 8'h59;
    if (v[3:0] == 4'd0)            return {v[7:4] - 4'd1, 4'd9};
    return v - 8'h01;
  endfunction

  function automatic logic [7:0] field_mask(input state_t s);
    case (s)
      SET_HH:  return 8'h30;
      SET_MM:  return 8'h0C;
      SET_SS:  return 8'h03;
      default: return 8'h00;
    endcase
  endfunction

  assign mode_edge = btn_mode & ~btn_mode_q;
  assign inc_edge  = btn_inc  & ~btn_inc_q;
  assign dec_edge  = btn_dec  & ~btn_dec_q;
  assign any_edge  = mode_edge | inc_edge | dec_edge;
  assign mode      = state_q;

`ifdef CLOCK_SET_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Inactivity counter: ticks in a SET state since the last button edge.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_hit   = 1'b0;
    if ((state_q == RUN) || any_edge) begin
      tmo_cnt_d = '0;
    end else if (tick) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_TICKS - 1)) begin
        tmo_cnt_d = '0;
        tmo_hit   = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
  end
`else
  logic unused_timeout;
  assign tmo_hit        = 1'b0;
  assign unused_timeout = (TIMEOUT_TICKS != 0);
`endif

  // Next-state, edit datapath, commit and blink decode.
  always_comb begin
    state_d     = state_q;
    hh_d        = hh_q;
    mm_d        = mm_q;
    ss_d        = ss_q;
    pm_d        = pm_q;
    load_d      = 1'b0;
    load_time_d = load_time;
    load_pm_d   = load_pm;
    blink_rst   = 1'b0;
    hh_step     = inc_edge ? hour_inc(hh_q) : hour_dec(hh_q);

    if (state_q == RUN) begin
      if (mode_edge) begin
        hh_d    = cur_time[23:16];
        mm_d    = cur_time[15:8];
        ss_d    = cur_time[7:0];
        pm_d    = cur_pm;
        state_d = SET_HH;
      end
    end else if (mode_edge) begin
      blink_rst = 1'b1;
      case (state_q)
        SET_HH:  state_d = SET_MM;
        SET_MM:  state_d = SET_SS;
        default: begin
          state_d     = RUN;
          load_d      = 1'b1;
          load_time_d = {hh_q, mm_q, ss_q};
          load_pm_d   = pm_q;
        end
      endcase
    end else if (inc_edge ^ dec_edge) begin
      blink_rst = 1'b1;
      case (state_q)
        SET_HH: begin
          hh_d = hh_step[7:0];
          pm_d = pm_q ^ hh_step[8];
        end
        SET_MM:  mm_d = inc_edge ? ms_inc(mm_q) : ms_dec(mm_q);
        default: ss_d = inc_edge ? ms_inc(ss_q) : ms_dec(ss_q);
      endcase
    end else if (tmo_hit) begin
      state_d = RUN;
    end

    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if ((state_q == RUN) || (state_d == RUN) || blink_rst) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    blank_mask_d = blink_ph_d ? field_mask(state_d) : 8'h00;
    run_en_d     = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      btn_mode_q  <= 1'b0;
      btn_inc_q   <= 1'b0;
      btn_dec_q   <= 1'b0;
      hh_q        <= 8'h12;
      mm_q        <= 8'h00;
      ss_q        <= 8'h00;
      pm_q        <= 1'b0;
      load        <= 1'b0;
      load_time   <= 24'h120000;
      load_pm     <= 1'b0;
      run_en      <= 1'b1;
      blank_mask  <= 8'h00;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      btn_mode_q  <= btn_mode;
      btn_inc_q   <= btn_inc;
      btn_dec_q   <= btn_dec;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      pm_q        <= pm_d;
      load        <= load_d;
      load_time   <= load_time_d;
      load_pm     <= load_pm_d;
      run_en      <= run_en_d;
      blank_mask  <= blank_mask_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
`ifdef CLOCK_SET_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

endmodule
